// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: latency sequencer for the shared mul/div unit and HI/LO.
// Ports: clk, rst (sync, active-low), muldiv_start, mul0_div1_sel,
//   div_zero, hilo_rd, flushE -> busy, stall_req, hilo_we, op_div, cnt.
// Optional: MULDIV_DIVZERO_FAST_EN finishes divide-by-zero after 1 cycle.
module muldiv_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             muldiv_start,
  input  logic             mul0_div1_sel,
  input  logic             div_zero,
  input  logic             hilo_rd,
  input  logic             flushE,
  output logic             busy,
  output logic             stall_req,
  output logic             hilo_we,
  output logic             op_div,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_WRITE
  } state_t;

  localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op_div;
  logic             r_busy;
  logic             r_hilo_we;

  logic             w_accept;
  logic [CNT_W-1:0] w_load;

  assign w_accept = muldiv_start & ~flushE
                  & (r_state == S_IDLE);

`ifdef MULDIV_DIVZERO_FAST_EN
  // HI/LO are undefined on /0, so skip the iteration.
  always_comb begin
    w_load = mul0_div1_sel ? DIV_M1 : MUL_M1;
    if (mul0_div1_sel && div_zero)
      w_load = '0;
  end
`else
  logic w_unused_dz;
  assign w_unused_dz = div_zero;
  assign w_load = mul0_div1_sel ? DIV_M1 : MUL_M1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_busy    <= 1'b0;
      r_hilo_we <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state  <= S_BUSY;
            r_op_div <= mul0_div1_sel;
            r_cnt    <= w_load;
            r_busy   <= 1'b1;
          end
        end
        S_BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= S_WRITE;
            r_hilo_we <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_hilo_we <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_busy    <= 1'b0;
          r_hilo_we <= 1'b0;
        end
      endcase
    end
  end

  // A flushed instruction is dead; it must not hold the pipe.
  assign stall_req = r_busy & (muldiv_start | hilo_rd) & ~flushE;
  assign busy      = r_busy;
  assign hilo_we   = r_hilo_we;
  assign op_div    = r_op_div;
  assign cnt       = r_cnt;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencer for the shared multiply/divide unit and its HI/LO result registers in the pipelined MIPS32 core.
- Accepts mult/div issue requests from the Execute stage and tracks the unit's fixed latency.
- Pulses the HI/LO write enable when a result is ready.
- Requests a pipeline stall whenever a new mul/div, or an mfhi/mflo, would collide with an operation still in flight.

Parameters:
- MUL_LAT, 4: multiply latency in cycles, 1..(2^CNT_W - 1).
- DIV_LAT, 32: divide latency in cycles, 1..(2^CNT_W - 1).
- CNT_W, 6: latency counter width.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Synchronous, active-low reset: sampled on the clk rising edge, and the block resets when rst=0.
- muldiv_start  in  1  Mul/div instruction present in Execute this cycle.
- mul0_div1_sel  in  1  0 = multiply, 1 = divide; qualified by muldiv_start.
- div_zero  in  1  Divisor equals zero; used only when the feature below is compiled in.
- hilo_rd  in  1  mfhi/mflo present in Execute this cycle.
- flushE  in  1  Execute stage is being flushed this cycle.
- busy  out  1  Operation in flight (state != IDLE).
- stall_req  out  1  Stall request to the hazard unit.
- hilo_we  out  1  One-cycle write enable for the HI and LO registers.
- op_div  out  1  Type of the in-flight or last-completed operation.
- cnt  out  CNT_W  Remaining-cycle counter, for debug.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, cnt=0, op_div=0.
  - busy=0, hilo_we=0, stall_req=0.
  - Reset mid-operation aborts the operation with no hilo_we pulse.
- States: IDLE, BUSY, WRITE.
- accept = muldiv_start & ~flushE & (state==IDLE).
- IDLE:
  - On accept: go to BUSY, op_div <= mul0_div1_sel, cnt <= (div ? DIV_LAT : MUL_LAT) - 1.
  - Otherwise stay in IDLE.
- BUSY:
  - If cnt==0, go to WRITE; otherwise cnt <= cnt - 1.
  - BUSY lasts exactly LAT cycles.
- WRITE:
  - hilo_we=1 for exactly this one cycle, then go to IDLE unconditionally.
  - A start arriving during WRITE is stalled, not accepted.
- Timing: accept in cycle 0 gives busy=1 in cycles 1..LAT+1 and hilo_we=1 in cycle LAT+1. The earliest next accept is cycle LAT+2.
- stall_req (combinational) = busy & (muldiv_start | hilo_rd) & ~flushE.
  - An mfhi/mflo issued in IDLE, including the cycle after WRITE, never stalls.
  - A flushed Execute instruction never stalls and is never accepted.
- Simultaneous muldiv_start and hilo_rd in IDLE: the start is accepted with no stall. A single instruction never asserts both; if both are asserted, start wins.
- hilo_we is a registered (state-decoded) output with no combinational path from inputs. stall_req is combinational.
- op_div holds its value after completion until the next accept.
- cnt never underflows; it reads 0 in IDLE and WRITE.

Optional Feature:
- Macro: MULDIV_DIVZERO_FAST_EN.
- Defined: an accepted divide with div_zero=1 loads cnt=0. BUSY then lasts 1 cycle and hilo_we occurs in cycle 2 after accept. The HI/LO contents are architecturally undefined (MIPS behaviour).
- Undefined: div_zero is ignored and all divides take DIV_LAT.

Test Plan:
1. Reset, then MUL_LAT=4: muldiv_start=1, mul0_div1_sel=0 in cycle 0 -> busy=1 in cycles 1-5, cnt=3,2,1,0 in cycles 1-4, hilo_we=1 only in cycle 5, op_div=0, IDLE in cycle 6.
2. DIV_LAT=32 divide, then hilo_rd=1 held from cycle 3 -> stall_req=1 in cycles 3-33, hilo_we in cycle 33, stall_req=0 in cycle 34 with hilo_rd still high.
3. Back-to-back mult, then mult (second start asserted from cycle 1) -> stall_req=1 in cycles 1-5, second accept in cycle 6, second hilo_we in cycle 11.
4. muldiv_start=1 with flushE=1 in IDLE -> no accept, busy stays 0, stall_req=0. Repeat with flushE=1 while BUSY -> stall_req=0 and the in-flight op completes normally.
5. rst=0 in cycle 10 of a divide -> next cycle state=IDLE, busy=0, cnt=0, and no hilo_we ever follows.
6. MULDIV_DIVZERO_FAST_EN defined, divide with div_zero=1 in cycle 0 -> hilo_we in cycle 2, busy=0 in cycle 3. With the macro undefined -> hilo_we in cycle 33.
